// File: rtl/serial_mux_lut_gate_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_mux_lut_gate_if
// Description : Start/busy/done handshake and operand bus for the bit-serial
//               truth-table logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_mux_lut_gate_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       tt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  // Requester side: issues operations and observes completion
  modport master (
    output start, a, b, tt,
    input  busy, done, result
  );

  // Logic unit side
  modport slave (
    input  start, a, b, tt,
    output busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/serial_mux_lut_gate.sv
`default_nettype none
// ============================================================================
// Module      : serial_mux_lut_gate
// Description : Bit-serial programmable 2-input logic unit. Applies the
//               function held in a 4-entry truth table to two WIDTH-bit
//               operands, one bit per clock, LSB first, via a 2:1 mux tree.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mux_lut_gate #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  serial_mux_lut_gate_if.slave  bus
);

  localparam int                c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_tt;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_result;
  logic               r_busy;
  logic               r_done;

  logic               w_abit;
  logic               w_bbit;
  logic               w_pair_lo;
  logic               w_pair_hi;
  logic               w_bit;
  logic [WIDTH-1:0]   w_shift_next;

  // Operands are shifted right each RUN cycle, so the current bit is always bit 0
  assign w_abit = r_a[0];
  assign w_bbit = r_b[0];

  // Mux tree: b picks within each pair, a picks between the pairs
  assign w_pair_lo = w_bbit ? r_tt[1] : r_tt[0];
  assign w_pair_hi = w_bbit ? r_tt[3] : r_tt[2];
  assign w_bit     = w_abit ? w_pair_hi : w_pair_lo;

  // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB
  assign w_shift_next = (r_shift >> 1) | (WIDTH'(w_bit) << (WIDTH - 1));

  // Control FSM and datapath registers; all outputs registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_tt     <= '0;
      r_shift  <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_tt    <= bus.tt;
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_shift <= w_shift_next;
          if (r_cnt == c_last) begin
            r_result <= w_shift_next;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_serial_mux_lut_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_mux_lut_gate
// Description : Self-checking bench for serial_mux_lut_gate (WIDTH=8 and
//               WIDTH=1 instances) against a behavioural truth-table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_mux_lut_gate;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_mux_lut_gate_if #(.WIDTH(W)) if8 ();
  serial_mux_lut_gate_if #(.WIDTH(1)) if1 ();

  serial_mux_lut_gate #(.WIDTH(W)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  serial_mux_lut_gate #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each result bit is the truth-table entry addressed by {a_i, b_i}
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] tt);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = tt[2 * int'(a[i]) + int'(b[i])];
    return r;
  endfunction

  // Issue one operation from a negedge; returns at the negedge where done is seen
  task automatic run8(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] tt, input logic [W-1:0] exp, input logic [W-1:0] prev,
                      input bit scramble, input bit mid_start);
    int edges;
    int busy_cnt;
    bit seen;
    if8.a     = a;
    if8.b     = b;
    if8.tt    = tt;
    if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    edges     = 1;
    busy_cnt  = 0;
    seen      = 1'b0;
    check({tag, "_busy_after_accept"}, if8.busy, 1);
    for (int k = 0; k < W + 4 && !seen; k++) begin
      if (if8.done) begin
        seen = 1'b1;
      end else begin
        if (if8.busy) busy_cnt++;
        if (k == 0 || k == W - 1) check({tag, "_result_held"}, if8.result, prev);
        if (scramble) begin
          if8.a  = W'($urandom);
          if8.b  = W'($urandom);
          if8.tt = 4'($urandom);
        end
        if (mid_start && k == 2) begin
          if8.start = 1'b1;
          if8.a     = '0;
          if8.b     = '0;
          if8.tt    = 4'b0111;
        end else begin
          if8.start = 1'b0;
        end
        @(negedge clk);
        edges++;
      end
    end
    if8.start = 1'b0;
    check({tag, "_latency"}, seen ? edges : 0, W + 1);
    check({tag, "_busy_cycles"}, busy_cnt, W);
    check({tag, "_result"}, if8.result, exp);
    check({tag, "_busy_at_done"}, if8.busy, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rexp, prev;
    logic [3:0]   rtt;
    logic [3:0]   ttv;
    int           dcount;

    rst       = 1'b1;
    if8.start = 1'b0;
    if8.a     = '0;
    if8.b     = '0;
    if8.tt    = '0;
    if1.start = 1'b0;
    if1.a     = '0;
    if1.b     = '0;
    if1.tt    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", if8.busy, 0);
    check("rst_done", if8.done, 0);
    check("rst_result", if8.result, 0);
    check("rst_w1_done", if1.done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single AND operation, then result must hold
    run8("and", 8'hF0, 8'hCC, 4'b1000, 8'hC0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("and_done_pulse_end", if8.done, 0);
    check("and_hold", if8.result, 8'hC0);
    check("and_idle", if8.busy, 0);
    repeat (2) @(negedge clk);

    // Back-to-back: second start presented during the DONE cycle
    run8("or", 8'hF0, 8'hCC, 4'b1110, 8'hFC, 8'hC0, 1'b0, 1'b0);
    run8("xor", 8'hF0, 8'hCC, 4'b0110, 8'h3C, 8'hFC, 1'b0, 1'b0);
    @(negedge clk);
    check("xor_done_pulse_end", if8.done, 0);

    // Start during RUN must be ignored
    run8("ign", 8'hFF, 8'h0F, 4'b1000, 8'h0F, 8'h3C, 1'b0, 1'b1);
    @(negedge clk);
    check("ign_single_done", if8.done, 0);
    check("ign_no_restart", if8.busy, 0);
    @(negedge clk);

    // Reset in the middle of an operation
    if8.a     = 8'h5A;
    if8.b     = 8'h3C;
    if8.tt    = 4'b1110;
    if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", if8.busy, 0);
    check("mid_rst_done", if8.done, 0);
    check("mid_rst_result", if8.result, 0);
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (if8.done) dcount++;
    end
    check("mid_rst_no_done", dcount, 0);
    run8("post_rst", 8'hAA, 8'h55, 4'b0110, 8'hFF, 8'h00, 1'b0, 1'b0);
    prev = 8'hFF;

    // Randomized operations with operands scrambled during RUN
    for (int n = 0; n < 20; n++) begin
      int gap;
      gap  = $urandom_range(0, 2);
      for (int g = 0; g < gap + 1; g++) @(negedge clk);
      ra   = W'($urandom);
      rb   = W'($urandom);
      rtt  = 4'($urandom);
      rexp = model(ra, rb, rtt);
      run8("rand", ra, rb, rtt, rexp, prev, 1'b1, 1'b0);
      prev = rexp;
    end
    @(negedge clk);

    // WIDTH=1: exhaustive over operand bits and truth tables
    for (int t = 0; t < 16; t++) begin
      for (int ab = 0; ab < 4; ab++) begin
        ttv       = 4'(t);
        if1.a     = 1'(ab >> 1);
        if1.b     = 1'(ab & 1);
        if1.tt    = ttv;
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        check("w1_busy", if1.busy, 1);
        check("w1_early_done", if1.done, 0);
        @(negedge clk);
        check("w1_done", if1.done, 1);
        check("w1_result", if1.result, (t >> ab) & 1);
        @(negedge clk);
        check("w1_done_end", if1.done, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
